// File: rtl/dmem_stage_pkg.sv
// Shared definitions for the data-memory stage.
// Contents: FSM state encoding, error codes, op codes and the request check
// helper that classifies a request at acceptance time.
package dmem_stage_pkg;

  // StXfer is the cycle between the array access edge and the response. On
  // the error path it is a pure delay with no array access.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StXfer = 2'b10,
    StResp = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ErrOk    = 2'b00,
    ErrAlign = 2'b01,
    ErrRange = 2'b10,
    ErrBoth  = 2'b11
  } err_e;

  typedef enum logic {
    OpLoad  = 1'b0,
    OpStore = 1'b1
  } op_e;

  // Priority: both requests > misaligned > out of range. The word index is
  // compared at full width so high addresses never wrap into the array.
  function automatic err_e req_err(input logic        rd,
                                   input logic        wr,
                                   input logic [31:0] addr,
                                   input int unsigned depth);
    err_e res;
    if (rd && wr) begin
      res = ErrBoth;
    end else if (addr[1:0] != 2'b00) begin
      res = ErrAlign;
    end else if ({2'b00, addr[31:2]} >= depth) begin
      res = ErrRange;
    end else begin
      res = ErrOk;
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM, no reset.
// Ports:
//   clk_i    clock
//   en_i     access enable for this edge
//   we_i     write when enabled, otherwise read
//   idx_i    word index
//   wdata_i  write data
//   rdata_o  registered read data, updated only on enabled reads
module dmem_array #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned IdxW  = 10
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem[idx_i] <= wdata_i;
      end else begin
        rdata_o <= mem[idx_i];
      end
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// Data-memory stage: executes lw/sw from the ALU address against an internal
// word array with a fixed wait latency and stalls the CPU until done.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   Addr, wdata    byte address and store data, latched at acceptance
//   MemRd, MemWr   load / store request, held high until done
//   rdata          registered load result
//   done           one-cycle completion pulse (also on error completion)
//   stall          (MemRd|MemWr) & ~done
//   err            error code, valid only while done is high
module dmem_stage
  import dmem_stage_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Addr,
  input  logic [31:0] wdata,
  input  logic        MemRd,
  input  logic        MemWr,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic [1:0]  err
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e            state_q;
  logic [3:0]        cnt_q;
  err_e              err_q;
  op_e               op_q;
  logic [IdxW-1:0]   idx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ram_rdata;
  logic              ram_en;
  logic              ram_we;
  err_e              new_err;

  assign new_err = req_err(MemRd, MemWr, Addr, DEPTH_WORDS);

  // Only ok requests ever reach StWait, so no error qualification is needed.
  assign ram_en = (state_q == StWait) && (cnt_q == 4'd0);
  assign ram_we = ram_en && (op_q == OpStore);

  dmem_array #(
    .Depth (DEPTH_WORDS),
    .IdxW  (IdxW)
  ) u_array (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      err_q   <= ErrOk;
      op_q    <= OpLoad;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (MemRd || MemWr) begin
            err_q   <= new_err;
            // MemRd&MemWr is classified as a load so its error clears rdata.
            op_q    <= MemRd ? OpLoad : OpStore;
            idx_q   <= Addr[IdxW+1:2];
            wdata_q <= wdata;
            if (new_err == ErrOk) begin
              state_q <= StWait;
              cnt_q   <= 4'(LATENCY - 1);
            end else begin
              state_q <= StXfer;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StXfer;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StXfer: begin
          state_q <= StResp;
          if (op_q == OpLoad) begin
            rdata_q <= (err_q == ErrOk) ? ram_rdata : 32'd0;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done  = (state_q == StResp);
  assign err   = done ? err_q : ErrOk;
  assign rdata = rdata_q;
  assign stall = (MemRd | MemWr) & ~done;

endmodule

// File: tb/tb_dmem_stage.sv
// Scoreboard bench for dmem_stage: the driver pushes the response predicted
// by a word-array reference model, a negedge monitor pops it on every done.
module tb_dmem_stage;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Addr;
  logic [31:0] wdata;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic [1:0]  err;

  dmem_stage #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Addr  (Addr),
    .wdata (wdata),
    .MemRd (MemRd),
    .MemWr (MemWr),
    .rdata (rdata),
    .done  (done),
    .stall (stall),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    bit          chk;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [int unsigned];
  int          checks = 0;
  int          passes = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endfunction

  // Monitor: one expected response per done pulse; err must be 00 otherwise.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("err", {30'd0, err}, {30'd0, mon_e.err});
          if (mon_e.chk) check("rdata", rdata, mon_e.rdata);
        end
      end else begin
        check("err_idle", {30'd0, err}, 32'd0);
      end
    end
  end

  // Called at a negedge. b2b: previous request still held, DUT is in RESP.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit b2b, input bit hold,
                        input bit toggle);
    exp_t        e;
    int unsigned widx;
    int          k;
    int          lat;
    widx    = a / 32'd4;
    e.rdata = 32'd0;
    e.chk   = 1'b0;
    if (rd && wr)                  e.err = 2'b11;
    else if ((a % 32'd4) != 32'd0) e.err = 2'b01;
    else if (widx >= DEPTH)        e.err = 2'b10;
    else                           e.err = 2'b00;
    if (e.err == 2'b00) begin
      if (wr) begin
        mem_m[widx] = wd;
      end else if (mem_m.exists(widx)) begin
        e.rdata = mem_m[widx];
        e.chk   = 1'b1;
      end
    end else if (rd && !wr) begin
      e.chk = 1'b1;
    end
    lat = (e.err == 2'b00) ? int'(LAT) + 2 : 2;
    sb.push_back(e);
    MemRd = rd;
    MemWr = wr;
    Addr  = a;
    wdata = wd;
    if (b2b) begin
      @(negedge clk);
      check("stall_b2b", {31'd0, stall}, 32'd1);
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (toggle && k == 1) begin
        Addr  = $urandom();
        wdata = $urandom();
      end
      if (!done) check("stall_busy", {31'd0, stall}, 32'd1);
    end while (!done && k < 40);
    check("latency", 32'(k), 32'(lat));
    check("stall_done", {31'd0, stall}, 32'd0);
    if (!hold) begin
      MemRd = 1'b0;
      MemWr = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  bit          rd;
  bit          wr;
  bit          hold;
  bit          hold_prev;
  int unsigned r;
  logic [31:0] a;

  initial begin
    rst_n = 1'b0;
    MemRd = 1'b0;
    MemWr = 1'b0;
    Addr  = 32'd0;
    wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {30'd0, err}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load same word.
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    // Misaligned load, array unchanged.
    do_req(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    // Out-of-range store must not alias into the last word.
    do_req(1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 32'h1000, 32'h11111111, 1'b0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, 1'b0, 1'b0);
    // Both requests plus misalignment: err 11 wins, no access.
    do_req(1'b1, 1'b1, 32'h12, 32'h77, 1'b0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset during WAIT abandons the store.
    do_req(1'b0, 1'b1, 32'h20, 32'h000055AA, 1'b0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    MemWr = 1'b1;
    Addr  = 32'h20;
    wdata = 32'h1234;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_err", {30'd0, err}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    MemWr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);

    // Back-to-back with inputs toggled mid-WAIT.
    do_req(1'b0, 1'b1, 32'h8, 32'hA5, 1'b0, 1'b1, 1'b1);
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 1'b1);

    // Fill a small region, then random mixed traffic.
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 1'b1, 32'(i) * 32'd4, $urandom(), 1'b0, 1'b0, 1'b0);
    end
    hold_prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      a  = 32'($urandom_range(0, 15)) * 32'd4;
      rd = 1'($urandom_range(0, 1));
      wr = !rd;
      if (r == 7) begin
        a = a + 32'($urandom_range(1, 3));
      end else if (r == 8) begin
        a = $urandom();
        a[1:0] = 2'b00;
        if (a < 32'h1000) a = a | 32'h1000;
      end else if (r == 9) begin
        rd = 1'b1;
        wr = 1'b1;
      end
      hold = (i != 59) && (1'($urandom_range(0, 1)) == 1'b1);
      do_req(rd, wr, a, $urandom(), hold_prev, hold, 1'($urandom_range(0, 1)));
      hold_prev = hold;
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
